// File: rtl/exp_golomb_bit_aligner.sv
// -----------------------------------------------------------------------------
// exp_golomb_bit_aligner
//   Bit-level front end for the Exp-Golomb decoder and slice-header parser.
//   - Accepts NAL payload bytes and removes emulation-prevention bytes
//     (00 00 03 -> 00 00) when EPB_EN is set.
//   - Presents a 16-bit MSB-first window whose bit [15] is the next unparsed bit.
//   - Advances the window by cons_len bits whenever downstream reports use.
//
// Parameters
//   BUF_W   bit-buffer depth in bits (multiple of 8, >= 24)
//   EPB_EN  1 = strip emulation-prevention bytes, 0 = pass every byte
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous clear for a new NAL unit; overrides everything else
//   axiiv      input byte valid
//   axiid      input byte, first bitstream bit in [7]
//   axiir      ready for an input byte
//   axiov      window valid (at least 16 bits buffered)
//   axiod      16-bit window, next unparsed bit in [15]
//   cons_valid downstream consumed cons_len bits this cycle
//   cons_len   bits consumed, legal range 1..16
//   epb_count  emulation-prevention bytes removed since reset/flush (saturating)
// -----------------------------------------------------------------------------
module exp_golomb_bit_aligner #(
  parameter int BUF_W  = 32,
  parameter bit EPB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        axiiv,
  input  logic [7:0]  axiid,
  output logic        axiir,
  output logic        axiov,
  output logic [15:0] axiod,
  input  logic        cons_valid,
  input  logic [4:0]  cons_len,
  output logic [15:0] epb_count
);

  localparam int FW = $clog2(BUF_W) + 1;
  localparam logic [FW-1:0] FILL_ROOM = FW'(BUF_W - 8);
  localparam logic [FW-1:0] WIN_BITS  = FW'(16);
  localparam logic [FW-1:0] BYTE_BITS = FW'(8);

  // Saturating 16-bit increment for the EPB counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Zero-run tracker: counts consecutive zero bytes, capped at 2.
  function automatic logic [1:0] zero_run_step(input logic [1:0] zr, input logic [7:0] b);
    if (b != 8'h00) begin
      return 2'd0;
    end else if (zr >= 2'd2) begin
      return 2'd2;
    end else begin
      return zr + 2'd1;
    end
  endfunction

  logic [BUF_W-1:0] bits_r;
  logic [FW-1:0]    fill_r;
  logic [1:0]       zero_run_r;
  logic [15:0]      epb_count_r;

  logic             ready_s;
  logic             win_valid_s;
  logic [FW-1:0]    top_idx_s;
  logic             accept_s;
  logic             epb_s;
  logic             keep_s;
  logic             drop_s;
  logic             len_ok_s;
  logic             consume_s;
  logic [FW-1:0]    add_s;
  logic [FW-1:0]    sub_s;
  logic [FW-1:0]    fill_next_s;

  // Handshake and window decode from registered state; rst forces ready low at once.
  always_comb begin
    ready_s     = (fill_r <= FILL_ROOM) && rst;
    win_valid_s = (fill_r >= WIN_BITS);
    // Clamp the top index when the window is invalid so the select stays in range.
    if (win_valid_s) begin
      top_idx_s = fill_r - FW'(1);
    end else begin
      top_idx_s = FW'(15);
    end
  end

  // Accept / EPB / consume decisions and the next fill level.
  always_comb begin
    accept_s  = axiiv && ready_s;
    epb_s     = EPB_EN && (zero_run_r >= 2'd2) && (axiid == 8'h03);
    keep_s    = accept_s && !epb_s;
    drop_s    = accept_s && epb_s;
    len_ok_s  = (cons_len >= 5'd1) && (cons_len <= 5'd16);
    consume_s = cons_valid && win_valid_s && len_ok_s;
    if (keep_s) begin
      add_s = BYTE_BITS;
    end else begin
      add_s = {FW{1'b0}};
    end
    if (consume_s) begin
      sub_s = {{(FW-5){1'b0}}, cons_len};
    end else begin
      sub_s = {FW{1'b0}};
    end
    // Ready is judged on pre-consume fill, so this never exceeds BUF_W.
    fill_next_s = fill_r + add_s - sub_s;
  end

  // Output drive.
  always_comb begin
    axiir     = ready_s;
    axiov     = win_valid_s;
    epb_count = epb_count_r;
    if (win_valid_s) begin
      axiod = bits_r[top_idx_s -: 16];
    end else begin
      axiod = 16'h0000;
    end
  end

  // Bit buffer, fill level, zero-run tracker and EPB counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_r      <= {BUF_W{1'b0}};
      fill_r      <= {FW{1'b0}};
      zero_run_r  <= 2'd0;
      epb_count_r <= 16'd0;
    end else if (flush) begin
      bits_r      <= {BUF_W{1'b0}};
      fill_r      <= {FW{1'b0}};
      zero_run_r  <= 2'd0;
      epb_count_r <= 16'd0;
    end else begin
      fill_r <= fill_next_s;
      if (keep_s) begin
        // New byte enters at the LSB end; stale bits above fill are don't-care.
        bits_r     <= {bits_r[BUF_W-9:0], axiid};
        zero_run_r <= zero_run_step(zero_run_r, axiid);
      end else if (drop_s) begin
        zero_run_r  <= 2'd0;
        epb_count_r <= sat_inc16(epb_count_r);
      end else begin
        zero_run_r <= zero_run_r;
      end
    end
  end

endmodule
